fetch_unit: RTL

Instruction-fetch stage for the five-stage RV32I core. Holds the program counter and issues one request at a time to instruction memory over a valid/ready handshake. Delivers fetched instructions into the IF/ID register and redirects to the EX-stage branch target (`br_ctrl`/`br_pc`), discarding any wrong-path instruction. Honours the ID-stage stall by buffering one returned instruction.

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/if_hold_buf.sv | 31 +++
 rtl/fetch_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the RV32I instruction-fetch stage.
// Holds the FSM encodings, IF/ID bundle type and PC alignment helper.
package fetch_unit_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry {pc, inst} holding buffer for a word returned while ID stalls.
// Clear wins over load so a redirect always empties it.
module if_hold_buf
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic        clr,
    input  logic [31:0] pc_in,
    input  logic [31:0] inst_in,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        valid
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= '0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= pc_in;
            inst  <= inst_in;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake,
// IF/ID register, EX redirect with wrong-path drop, one-word stall buffer.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ex_br_ctrl,
    input  logic [31:0] ex_br_pc,
    input  logic        id_stall,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid
);

    logic [1:0]  state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] req_pc, req_pc_n;
    logic        drop, drop_n;
    if_id_t      if_id, if_id_n;

    logic        buf_load, buf_clr, buf_valid;
    logic [31:0] buf_pc, buf_inst;
    logic        req_fire;

    assign imem_req_valid = (state == ST_FETCH);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign if_id_pc    = if_id.pc;
    assign if_id_inst  = if_id.inst;
    assign if_id_valid = if_id.valid;

    if_hold_buf u_hold_buf (
        .clk     (clk),
        .rstn    (rstn),
        .load    (buf_load),
        .clr     (buf_clr),
        .pc_in   (req_pc),
        .inst_in (imem_resp_data),
        .pc      (buf_pc),
        .inst    (buf_inst),
        .valid   (buf_valid)
    );

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        req_pc_n = req_pc;
        drop_n   = drop;
        if_id_n  = if_id;
        buf_load = 1'b0;
        buf_clr  = 1'b0;

        // ID consumed the current entry; a new word below may overwrite
        if (!id_stall) begin
            if_id_n.valid = 1'b0;
            if_id_n.inst  = NOP_INST;
        end

        if (ex_br_ctrl) begin
            pc_n          = word_align(ex_br_pc);
            if_id_n.valid = 1'b0;
            if_id_n.inst  = NOP_INST;
            buf_clr       = 1'b1;
            case (state)
                ST_FETCH: begin
                    if (req_fire) begin
                        req_pc_n = pc;
                        drop_n   = 1'b1;
                        state_n  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        drop_n  = 1'b0;
                        state_n = ST_FETCH;
                    end else begin
                        drop_n  = 1'b1;
                    end
                end
                default: state_n = ST_FETCH;
            endcase
        end else begin
            case (state)
                ST_FETCH: begin
                    if (req_fire) begin
                        pc_n     = pc + 32'd4;
                        req_pc_n = pc;
                        state_n  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        if (drop) begin
                            drop_n  = 1'b0;
                            state_n = ST_FETCH;
                        end else if (!id_stall || !if_id.valid) begin
                            if_id_n = '{req_pc, imem_resp_data, 1'b1};
                            state_n = ST_FETCH;
                        end else begin
                            buf_load = 1'b1;
                            state_n  = ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (!id_stall && buf_valid) begin
                        if_id_n = '{buf_pc, buf_inst, 1'b1};
                        buf_clr = 1'b1;
                        state_n = ST_FETCH;
                    end
                end
                default: state_n = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= ST_FETCH;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
            drop   <= 1'b0;
            if_id  <= '{RESET_PC, NOP_INST, 1'b0};
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            req_pc <= req_pc_n;
            drop   <= drop_n;
            if_id  <= if_id_n;
        end
    end

endmodule
